// File: rtl/pkg_dtypes.sv
`default_nettype none
// ============================================================================
//  Package     : pkg_dtypes
//  Description : Shared exec-unit / interconnect data types, including the
//                entry layout of the icon result-broadcast buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pkg_dtypes;

    // Number of icon interfaces (exec units) on the interconnect
    localparam int TOT_NUM_ICON_INTERFACES = 2;

    typedef logic [7:0]  type_exec_unit_addr;
    typedef logic [31:0] type_exec_unit_data;

    // Exec-unit receivers plus the store buffer and the mxreg receivers
    localparam int ICON_BCAST_NUM_RECEIVERS = TOT_NUM_ICON_INTERFACES + 2;

    typedef struct packed {
        type_exec_unit_addr                    src_addr;
        type_exec_unit_data                    data;
        logic [ICON_BCAST_NUM_RECEIVERS-1:0]   receivers;
    } type_icon_bcast_entry;

endpackage
`default_nettype wire

// File: rtl/icon_bcast_ring.sv
`default_nettype none
// ============================================================================
//  Module      : icon_bcast_ring
//  Description : DEPTH-entry circular storage for the broadcast buffer.
//                Holds packed entries, read/write pointers that wrap at
//                DEPTH-1 (DEPTH need not be a power of two) and an
//                occupancy counter. Push/pop qualification is the caller's.
//  Revision    : 1.0 - initial release
// ============================================================================
module icon_bcast_ring #(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH + 1),
    parameter int ENTRY_W = 44
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                push,
    input  logic                pop,
    input  logic [ENTRY_W-1:0]  push_entry,
    output logic [ENTRY_W-1:0]  head_entry,
    output logic [CNT_W-1:0]    count,
    output logic                empty,
    output logic                full
);
    import pkg_dtypes::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] c_last = PTR_W'(DEPTH - 1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    assign head_entry = mem[rd_ptr];
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));

    // Entry storage: written at wr_ptr on every accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointer and occupancy update; flush behaves like reset on the state
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == c_last) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == c_last) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/icon_bcast_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : icon_bcast_buffer
//  Description : Result-broadcast buffer between an exec unit ALU and the
//                interconnect. Queues results with a receiver list, presents
//                the head as a broadcast channel, accumulates per-receiver
//                success over any number of cycles and retires the head once
//                every targeted receiver has taken it.
//  Options     : ICON_BCAST_BUFFER_BYPASS_EN - zero-latency path from the
//                push inputs to the channel when the buffer is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module icon_bcast_buffer
    import pkg_dtypes::*;
#(
    parameter int DEPTH         = 4,
    parameter int NUM_RECEIVERS = pkg_dtypes::TOT_NUM_ICON_INTERFACES + 2,
    parameter int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_flush,
    input  logic                              i_push_valid,
    output logic                              o_push_ready,
    input  logic [$bits(type_exec_unit_addr)-1:0] i_push_addr,
    input  logic [$bits(type_exec_unit_data)-1:0] i_push_data,
    input  logic [NUM_RECEIVERS-1:0]          i_push_receivers,
    output logic                              o_ch_valid,
    output logic [$bits(type_exec_unit_addr)-1:0] o_ch_src_addr,
    output logic [$bits(type_exec_unit_data)-1:0] o_ch_data,
    output logic [NUM_RECEIVERS-1:0]          o_ch_pending,
    input  logic [NUM_RECEIVERS-1:0]          i_ch_success,
    output logic                              o_retire,
    output logic [CNT_W-1:0]                  o_count,
    output logic                              o_empty,
    output logic                              o_full
);

    localparam int ADDR_W  = $bits(type_exec_unit_addr);
    localparam int DATA_W  = $bits(type_exec_unit_data);
    localparam int ENTRY_W = ADDR_W + DATA_W + NUM_RECEIVERS;

    logic [ENTRY_W-1:0]       head_entry;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;
    logic [NUM_RECEIVERS-1:0] head_rcv;
    logic [NUM_RECEIVERS-1:0] cur_rcv;
    logic [NUM_RECEIVERS-1:0] acc_mask;
    logic                     empty;
    logic                     full;
    logic                     push_fire;
    logic                     bypass;
    logic                     ch_valid;
    logic                     done;
    logic                     ring_push;
    logic                     ring_pop;

    assign {head_addr, head_data, head_rcv} = head_entry;

    // No pass-through when full: a same-cycle retire does not free a slot
    assign o_push_ready = !full && !i_flush;
    assign push_fire    = i_push_valid && o_push_ready && !i_reset;

`ifdef ICON_BCAST_BUFFER_BYPASS_EN
    assign bypass = empty && push_fire;
`else
    assign bypass = 1'b0;
`endif

    assign ch_valid = !empty || bypass;

    // Channel source select: push inputs when bypassing, else the ring head
    always_comb begin
        o_ch_src_addr = '0;
        o_ch_data     = '0;
        cur_rcv       = '0;
        if (bypass) begin
            o_ch_src_addr = i_push_addr;
            o_ch_data     = i_push_data;
            cur_rcv       = i_push_receivers;
        end else if (!empty) begin
            o_ch_src_addr = head_addr;
            o_ch_data     = head_data;
            cur_rcv       = head_rcv;
        end
    end

    // acc_mask is always zero while empty, so bypass needs no special case
    assign o_ch_valid   = ch_valid;
    assign o_ch_pending = cur_rcv & ~acc_mask;
    assign done         = ch_valid && ((o_ch_pending & ~i_ch_success) == '0);
    assign o_retire     = done && !i_flush && !i_reset;

    // A fully-acknowledged bypassed entry never enters the ring
    assign ring_push = push_fire && !(bypass && done);
    assign ring_pop  = o_retire && !bypass;

    // Accumulate successes of still-pending receivers; clear on retire
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            acc_mask <= '0;
        end else if (done) begin
            acc_mask <= '0;
        end else begin
            acc_mask <= acc_mask | (i_ch_success & o_ch_pending);
        end
    end

    icon_bcast_ring #(
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W),
        .ENTRY_W (ENTRY_W)
    ) u_ring (
        .clk        (i_clk),
        .rst        (i_reset),
        .flush      (i_flush),
        .push       (ring_push),
        .pop        (ring_pop),
        .push_entry ({i_push_addr, i_push_data, i_push_receivers}),
        .head_entry (head_entry),
        .count      (o_count),
        .empty      (empty),
        .full       (full)
    );

    assign o_empty = empty;
    assign o_full  = full;

endmodule
`default_nettype wire

// File: tb/tb_icon_bcast_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icon_bcast_buffer
//  Description : Directed self-checking bench for icon_bcast_buffer
//                (DEPTH=4, NUM_RECEIVERS=4). Honours
//                ICON_BCAST_BUFFER_BYPASS_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icon_bcast_buffer;

    logic        clk = 1'b0;
    logic        reset, flush, push_valid, push_ready;
    logic [7:0]  push_addr, ch_src_addr;
    logic [31:0] push_data, ch_data;
    logic [3:0]  push_receivers, ch_pending, ch_success;
    logic        ch_valid, retire, empty, full;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    icon_bcast_buffer #(.DEPTH(4), .NUM_RECEIVERS(4), .CNT_W(3)) dut (
        .i_clk(clk), .i_reset(reset), .i_flush(flush),
        .i_push_valid(push_valid), .o_push_ready(push_ready),
        .i_push_addr(push_addr), .i_push_data(push_data),
        .i_push_receivers(push_receivers),
        .o_ch_valid(ch_valid), .o_ch_src_addr(ch_src_addr), .o_ch_data(ch_data),
        .o_ch_pending(ch_pending), .i_ch_success(ch_success),
        .o_retire(retire), .o_count(count), .o_empty(empty), .o_full(full)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs sampled 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; push_valid = 1'b0; push_addr = '0;
        push_data = '0; push_receivers = '0; ch_success = '0;
        step(); step();
        reset = 1'b0;
        settle();
        n_checks++; if (ch_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", ch_valid); else n_pass++;
        n_checks++; if (ch_pending !== 4'b0) $display("FAIL rst_pending: got %b want 0000", ch_pending); else n_pass++;
        n_checks++; if (retire !== 1'b0) $display("FAIL rst_retire: got %b want 0", retire); else n_pass++;
        n_checks++; if (count !== 3'd0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL rst_empty_full: got %b%b want 10", empty, full); else n_pass++;
        n_checks++; if (push_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", push_ready); else n_pass++;
        n_checks++; if (ch_data !== 32'h0 || ch_src_addr !== 8'h0) $display("FAIL rst_data: got %h/%h want 0/0", ch_src_addr, ch_data); else n_pass++;
    endtask

    task automatic test_basic();
        push_valid = 1'b1; push_addr = 8'h12; push_data = 32'hA5; push_receivers = 4'b0101;
        settle();
`ifndef ICON_BCAST_BUFFER_BYPASS_EN
        n_checks++; if (ch_valid !== 1'b0) $display("FAIL basic_latency: got %b want 0", ch_valid); else n_pass++;
`endif
        step();
        push_valid = 1'b0;
        settle();
        n_checks++; if (ch_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", ch_valid); else n_pass++;
        n_checks++; if (ch_pending !== 4'b0101) $display("FAIL basic_pending: got %b want 0101", ch_pending); else n_pass++;
        n_checks++; if (ch_src_addr !== 8'h12 || ch_data !== 32'hA5) $display("FAIL basic_head: got %h/%h want 12/a5", ch_src_addr, ch_data); else n_pass++;
        n_checks++; if (retire !== 1'b0) $display("FAIL basic_no_retire: got %b want 0", retire); else n_pass++;
        ch_success = 4'b0101;
        settle();
        n_checks++; if (retire !== 1'b1) $display("FAIL basic_retire: got %b want 1", retire); else n_pass++;
        step();
        ch_success = '0;
        settle();
        n_checks++; if (empty !== 1'b1 || count !== 3'd0) $display("FAIL basic_empty: got %b/%0d want 1/0", empty, count); else n_pass++;
    endtask

    task automatic test_partial();
        push_valid = 1'b1; push_data = 32'h11; push_receivers = 4'b1011;
        step();
        push_valid = 1'b0;
        settle();
        n_checks++; if (ch_pending !== 4'b1011) $display("FAIL part_p0: got %b want 1011", ch_pending); else n_pass++;
        ch_success = 4'b0001;
        settle();
        n_checks++; if (retire !== 1'b0) $display("FAIL part_r0: got %b want 0", retire); else n_pass++;
        step();
        ch_success = 4'b1001;
        settle();
        n_checks++; if (ch_pending !== 4'b1010) $display("FAIL part_p1: got %b want 1010", ch_pending); else n_pass++;
        n_checks++; if (retire !== 1'b0) $display("FAIL part_r1: got %b want 0", retire); else n_pass++;
        step();
        ch_success = 4'b0010;
        settle();
        n_checks++; if (ch_pending !== 4'b0010) $display("FAIL part_p2: got %b want 0010", ch_pending); else n_pass++;
        n_checks++; if (retire !== 1'b1) $display("FAIL part_r2: got %b want 1", retire); else n_pass++;
        step();
        ch_success = '0;
        settle();
        n_checks++; if (empty !== 1'b1) $display("FAIL part_empty: got %b want 1", empty); else n_pass++;
    endtask

    task automatic test_full_wrap();
        int exp_d[4] = '{4, 6, 7, 8};
        push_receivers = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            push_valid = 1'b1; push_data = 32'(k + 1);
            settle();
            n_checks++; if (push_ready !== (k < 4)) $display("FAIL wrap_ready%0d: got %b want %b", k, push_ready, (k < 4)); else n_pass++;
            step();
        end
        push_valid = 1'b0;
        settle();
        n_checks++; if (count !== 3'd4 || full !== 1'b1) $display("FAIL wrap_full: got %0d/%b want 4/1", count, full); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            ch_success = 4'b0001;
            settle();
            n_checks++; if (ch_data !== 32'(i + 1) || retire !== 1'b1) $display("FAIL wrap_ret%0d: got %0d/%b want %0d/1", i, ch_data, retire, i + 1); else n_pass++;
            step();
        end
        ch_success = '0;
        for (int k = 6; k <= 8; k++) begin
            push_valid = 1'b1; push_data = 32'(k);
            step();
        end
        push_valid = 1'b0;
        settle();
        n_checks++; if (count !== 3'd4) $display("FAIL wrap_count: got %0d want 4", count); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            ch_success = 4'b0001;
            settle();
            n_checks++; if (ch_data !== 32'(exp_d[i])) $display("FAIL wrap_order%0d: got %0d want %0d", i, ch_data, exp_d[i]); else n_pass++;
            step();
        end
        ch_success = '0;
        settle();
        n_checks++; if (empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", empty); else n_pass++;
    endtask

    task automatic test_full_retire();
        push_receivers = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            push_valid = 1'b1; push_data = 32'h21 + 32'(k);
            step();
        end
        push_data = 32'h99; ch_success = 4'b0001;
        settle();
        n_checks++; if (push_ready !== 1'b0) $display("FAIL fr_ready: got %b want 0", push_ready); else n_pass++;
        n_checks++; if (retire !== 1'b1) $display("FAIL fr_retire: got %b want 1", retire); else n_pass++;
        step();
        push_valid = 1'b0; ch_success = '0;
        settle();
        n_checks++; if (count !== 3'd3 || ch_data !== 32'h22) $display("FAIL fr_count: got %0d/%h want 3/22", count, ch_data); else n_pass++;
        ch_success = 4'b0001;
        step(); step(); step();
        ch_success = '0;
        settle();
        n_checks++; if (empty !== 1'b1) $display("FAIL fr_drain: got %b want 1", empty); else n_pass++;
    endtask

    task automatic test_clear(input bit use_reset);
        push_receivers = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            push_valid = 1'b1; push_data = 32'h31 + 32'(k);
            step();
        end
        push_valid = 1'b0; ch_success = 4'b0001;
        step();
        ch_success = '0;
        settle();
        n_checks++; if (ch_pending !== 4'b0010) $display("FAIL clr%0d_acc: got %b want 0010", use_reset, ch_pending); else n_pass++;
        if (use_reset) reset = 1'b1; else flush = 1'b1;
        ch_success = 4'b0010; push_valid = 1'b1; push_data = 32'h77;
        settle();
        n_checks++; if (retire !== 1'b0) $display("FAIL clr%0d_retire: got %b want 0", use_reset, retire); else n_pass++;
        step();
        reset = 1'b0; flush = 1'b0; push_valid = 1'b0; ch_success = '0;
        settle();
        n_checks++; if (count !== 3'd0 || ch_pending !== 4'b0 || ch_valid !== 1'b0) $display("FAIL clr%0d_state: got %0d/%b/%b want 0/0000/0", use_reset, count, ch_pending, ch_valid); else n_pass++;
        push_valid = 1'b1; push_data = 32'h55; push_receivers = 4'b0111;
        step();
        push_valid = 1'b0;
        settle();
        n_checks++; if (ch_pending !== 4'b0111 || ch_data !== 32'h55) $display("FAIL clr%0d_new: got %b/%h want 0111/55", use_reset, ch_pending, ch_data); else n_pass++;
        ch_success = 4'b0111;
        step();
        ch_success = '0;
        settle();
        n_checks++; if (empty !== 1'b1) $display("FAIL clr%0d_empty: got %b want 1", use_reset, empty); else n_pass++;
    endtask

    task automatic test_zero_receivers();
        push_valid = 1'b1; push_data = 32'hC0; push_receivers = 4'b0000;
        settle();
`ifdef ICON_BCAST_BUFFER_BYPASS_EN
        n_checks++; if (retire !== 1'b1) $display("FAIL zero_retire: got %b want 1", retire); else n_pass++;
        step();
        push_valid = 1'b0;
        settle();
`else
        n_checks++; if (retire !== 1'b0) $display("FAIL zero_early: got %b want 0", retire); else n_pass++;
        step();
        push_valid = 1'b0;
        settle();
        n_checks++; if (ch_valid !== 1'b1 || retire !== 1'b1) $display("FAIL zero_retire: got %b/%b want 1/1", ch_valid, retire); else n_pass++;
        step();
`endif
        n_checks++; if (count !== 3'd0 || empty !== 1'b1) $display("FAIL zero_empty: got %0d/%b want 0/1", count, empty); else n_pass++;
    endtask

    task automatic test_bypass();
        push_valid = 1'b1; push_addr = 8'h3C; push_data = 32'hB7; push_receivers = 4'b0001;
        ch_success = 4'b0001;
        settle();
`ifdef ICON_BCAST_BUFFER_BYPASS_EN
        n_checks++; if (ch_valid !== 1'b1 || ch_data !== 32'hB7 || retire !== 1'b1) $display("FAIL byp_same: got %b/%h/%b want 1/b7/1", ch_valid, ch_data, retire); else n_pass++;
        step();
        push_valid = 1'b0; ch_success = '0;
        settle();
        n_checks++; if (count !== 3'd0) $display("FAIL byp_count: got %0d want 0", count); else n_pass++;
        push_valid = 1'b1; push_receivers = 4'b0011; ch_success = 4'b0001;
        settle();
        n_checks++; if (ch_pending !== 4'b0011 || retire !== 1'b0) $display("FAIL byp_part: got %b/%b want 0011/0", ch_pending, retire); else n_pass++;
        step();
        push_valid = 1'b0; ch_success = '0;
        settle();
        n_checks++; if (count !== 3'd1 || ch_pending !== 4'b0010) $display("FAIL byp_acc: got %0d/%b want 1/0010", count, ch_pending); else n_pass++;
        ch_success = 4'b0010;
        step();
`else
        n_checks++; if (retire !== 1'b0 || ch_valid !== 1'b0) $display("FAIL nobyp_same: got %b/%b want 0/0", retire, ch_valid); else n_pass++;
        step();
        push_valid = 1'b0;
        settle();
        n_checks++; if (count !== 3'd1 || retire !== 1'b1) $display("FAIL nobyp_next: got %0d/%b want 1/1", count, retire); else n_pass++;
        step();
`endif
        ch_success = '0;
        settle();
        n_checks++; if (empty !== 1'b1) $display("FAIL byp_empty: got %b want 1", empty); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_full_wrap();
        test_full_retire();
        test_clear(1'b0);
        test_clear(1'b1);
        test_zero_receivers();
        test_bypass();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Run-time bound so the bench can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got timeout want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
